// File: rtl/gpu_pkg.sv
// Shared types for the voxel front end: packed voxel word and dispatcher state encoding.
// Width defaults here are the ones the shader array is built with.
package gpu_pkg;

  localparam int COORD_BITS_DEF   = 8;
  localparam int PALETTE_BITS_DEF = 8;
  localparam int PIXEL_BITS_DEF   = 8;

  // Field order matches the voxel memory word: {id,z,y,x}, x in the LSBs.
  typedef struct packed {
    logic [PALETTE_BITS_DEF-1:0] id;
    logic [COORD_BITS_DEF-1:0]   z;
    logic [COORD_BITS_DEF-1:0]   y;
    logic [COORD_BITS_DEF-1:0]   x;
  } voxel_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_RASTER,
    ST_RWAIT,
    ST_SHADE,
    ST_SWAIT,
    ST_READOUT,
    ST_DONE
  } disp_state_t;

endpackage

// File: rtl/pixel_scanner.sv
// Row-major row/col walker for the shared pixel bus; valid follows 'active' combinationally.
// Position advances only on valid&&ready, so it holds under backpressure and wraps to (0,0) after the last pixel.
module pixel_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                active,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                last_accept
);

  logic fire;
  logic last;

  assign out_valid   = active;
  assign fire        = active && out_ready;
  assign last        = (row == ROW_BITS'(ROWS - 1)) && (col == COL_BITS'(COLS - 1));
  assign last_accept = fire && last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (fire) begin
      if (col == COL_BITS'(COLS - 1)) begin
        col <= '0;
        row <= last ? '0 : row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/voxel_dispatcher.sv
// Frame sequencer for the pixel_shader array: fetch/broadcast each voxel, shade once, then stream the frame out.
// Voxel cost is at least 5 cycles; readout stalls on out_ready and a shader that never reports done stalls forever.
module voxel_dispatcher
  import gpu_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = COORD_BITS_DEF,
  parameter int PALETTE_BITS = PALETTE_BITS_DEF,
  parameter int PIXEL_BITS   = PIXEL_BITS_DEF,
  parameter int VADDR_BITS   = 10
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [VADDR_BITS-1:0]              voxel_count,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               vmem_rd,
  output logic [VADDR_BITS-1:0]              vmem_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] vmem_rdata,
  output logic [COORD_BITS-1:0]              voxel_x,
  output logic [COORD_BITS-1:0]              voxel_y,
  output logic [COORD_BITS-1:0]              voxel_z,
  output logic [PALETTE_BITS-1:0]            voxel_id,
  output logic                               do_rasterize,
  output logic                               do_shade,
  input  logic [ROWS*COLS-1:0]               rasterizing_done,
  input  logic [ROWS*COLS-1:0]               shading_done,
  output logic [ROW_BITS-1:0]                row,
  output logic [COL_BITS-1:0]                col,
  input  logic [PIXEL_BITS-1:0]              pixel,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PIXEL_BITS-1:0]              out_pixel,
  output logic [ROW_BITS-1:0]                out_row,
  output logic [COL_BITS-1:0]                out_col
);

  disp_state_t           state;
  logic [VADDR_BITS-1:0] idx;
  logic [VADDR_BITS-1:0] count;
  logic [VADDR_BITS-1:0] idx_next;
  logic                  blank;
  logic                  last_accept;

  assign idx_next = idx + VADDR_BITS'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      count        <= '0;
      blank        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      vmem_rd      <= 1'b0;
      vmem_addr    <= '0;
      voxel_x      <= '0;
      voxel_y      <= '0;
      voxel_z      <= '0;
      voxel_id     <= '0;
      do_rasterize <= 1'b0;
      do_shade     <= 1'b0;
    end else begin
      vmem_rd      <= 1'b0;
      do_rasterize <= 1'b0;
      do_shade     <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= voxel_count;
            idx   <= '0;
            busy  <= 1'b1;
            if (voxel_count == '0) begin
              state    <= ST_SHADE;
              do_shade <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              vmem_rd   <= 1'b1;
              vmem_addr <= '0;
            end
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          {voxel_id, voxel_z, voxel_y, voxel_x} <= vmem_rdata;
          do_rasterize <= 1'b1;
          state        <= ST_RASTER;
        end
        ST_RASTER: begin
          blank <= 1'b1;
          state <= ST_RWAIT;
        end
        // Done levels on the first wait cycle may still belong to the previous voxel.
        ST_RWAIT: begin
          if (blank) begin
            blank <= 1'b0;
          end else if (&rasterizing_done) begin
            idx <= idx_next;
            if (idx_next == count) begin
              state    <= ST_SHADE;
              do_shade <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              vmem_rd   <= 1'b1;
              vmem_addr <= idx_next;
            end
          end
        end
        ST_SHADE: begin
          blank <= 1'b1;
          state <= ST_SWAIT;
        end
        ST_SWAIT: begin
          if (blank) begin
            blank <= 1'b0;
          end else if (&shading_done) begin
            state <= ST_READOUT;
          end
        end
        ST_READOUT: begin
          if (last_accept) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pixel_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_scanner (
    .clock       (clock),
    .reset       (reset),
    .active      (state == ST_READOUT),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .row         (row),
    .col         (col),
    .last_accept (last_accept)
  );

  assign out_row   = row;
  assign out_col   = col;
  assign out_pixel = out_valid ? pixel : '0;

endmodule

// File: tb/tb_voxel_dispatcher.sv
// Scoreboard bench for voxel_dispatcher on a 4x4 shader array with modelled voxel memory, shader done levels and pixel bus.
module tb_voxel_dispatcher;
  import gpu_pkg::*;

  localparam int N  = 16;
  localparam int AB = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] voxel_count = '0;
  logic          busy, frame_done, vmem_rd, do_rasterize, do_shade, out_valid;
  logic          out_ready = 1'b1;
  logic [AB-1:0] vmem_addr;
  logic [31:0]   vmem_rdata = '0;
  logic [7:0]    voxel_x, voxel_y, voxel_z, voxel_id;
  logic [N-1:0]  rd_done = '1;
  logic [N-1:0]  sd_done = '1;
  logic [7:0]    row, col, pixel, out_pixel, out_row, out_col;
  logic [7:0]    salt8 = 8'h00;

  voxel_dispatcher dut (
    .clock(clock), .reset(reset), .start(start), .voxel_count(voxel_count),
    .busy(busy), .frame_done(frame_done), .vmem_rd(vmem_rd), .vmem_addr(vmem_addr),
    .vmem_rdata(vmem_rdata), .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z),
    .voxel_id(voxel_id), .do_rasterize(do_rasterize), .do_shade(do_shade),
    .rasterizing_done(rd_done), .shading_done(sd_done), .row(row), .col(col),
    .pixel(pixel), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clock = ~clock;

  voxel_t mem [0:15];

  // Registered voxel memory: data is only meaningful the cycle after a read.
  always @(posedge clock) vmem_rdata <= vmem_rd ? mem[vmem_addr[3:0]] : $urandom;

  assign pixel = {row[3:0], col[3:0]} ^ salt8;

  function automatic logic [7:0] pix_of(input logic [3:0] r, input logic [3:0] c);
    return {r, c} ^ salt8;
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int  cyc = 0, rd_cnt = 0, rast_cnt = 0, shade_cnt = 0, fdone_cnt = 0;
  int  exp_addr = 0, last_rast = 0, exp_gap = 0;
  bit  rast_pending = 0;
  int  m_delay = 3, m_extra = 0;
  bit  m_stale = 0;
  bit  bp_en = 0, bp_done = 0;
  int  bp_left = 0;
  int  rc [N];
  int  sc [N];
  voxel_t      vq[$];
  logic [23:0] pq[$];

  initial for (int i = 0; i < N; i++) begin rc[i] = 0; sc[i] = 0; end

  // Monitor: shader done model, scoreboard pops, timing and backpressure checks.
  initial forever begin
    voxel_t      v;
    logic [23:0] p;
    @(negedge clock);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rc[i] > 0) begin rc[i]--; if (rc[i] == 0) rd_done[i] = 1'b1; end
      if (sc[i] > 0) begin sc[i]--; if (sc[i] == 0) sd_done[i] = 1'b1; end
    end
    if (do_rasterize && !m_stale)
      for (int i = 0; i < N; i++) begin rd_done[i] = 1'b0; rc[i] = m_delay + ((i == 5) ? m_extra : 0); end
    if (do_shade && !m_stale)
      for (int i = 0; i < N; i++) begin sd_done[i] = 1'b0; sc[i] = m_delay; end
    if (vmem_rd) begin
      rd_cnt++;
      check_eq("vmem_addr", vmem_addr, exp_addr);
      exp_addr++;
    end
    if (rast_pending && (vmem_rd || do_shade)) begin
      check_eq("rwait_gap", cyc - last_rast, exp_gap);
      rast_pending = 0;
    end
    if (do_rasterize) begin
      rast_cnt++;
      last_rast = cyc;
      rast_pending = 1;
      if (vq.size() == 0) check_eq("spurious_rasterize", vq.size(), 1);
      else begin
        v = vq.pop_front();
        check_eq("voxel", {voxel_id, voxel_z, voxel_y, voxel_x}, v);
      end
    end
    if (do_shade) shade_cnt++;
    if (frame_done) fdone_cnt++;
    if (bp_left > 0) begin
      check_eq("bp_hold", {out_valid, out_row, out_col, out_pixel}, {1'b1, 8'd1, 8'd2, pix_of(4'd1, 4'd2)});
      bp_left--;
      if (bp_left == 0) out_ready = 1'b1;
    end else if (bp_en && !bp_done && out_valid && out_row == 8'd1 && out_col == 8'd2) begin
      out_ready = 1'b0;
      bp_left   = 5;
      bp_done   = 1;
    end
    if (out_valid && out_ready) begin
      if (pq.size() == 0) check_eq("spurious_pixel", pq.size(), 1);
      else begin
        p = pq.pop_front();
        check_eq("pixel", {out_row, out_col, out_pixel}, p);
      end
    end
  end

  task automatic prep_frame(input int cnt, input int d, input int extra, input bit stale);
    for (int i = 0; i < cnt; i++) vq.push_back(mem[i]);
    salt8 = 8'($urandom);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pq.push_back({8'(r), 8'(c), pix_of(4'(r), 4'(c))});
    exp_addr = 0;
    m_delay  = d;
    m_extra  = extra;
    m_stale  = stale;
    exp_gap  = stale ? 3 : d + extra + 1;
    rd_done  = '1;
    sd_done  = '1;
  endtask

  task automatic run_frame(input int cnt, input int d, input int extra, input bit stale,
                           input bit busy_start, input bit done_start);
    int b_rd, b_rast, b_shade, b_fd;
    bit seen;
    b_rd = rd_cnt; b_rast = rast_cnt; b_shade = shade_cnt; b_fd = fdone_cnt;
    prep_frame(cnt, d, extra, stale);
    @(negedge clock); start = 1'b1; voxel_count = AB'(cnt);
    @(negedge clock); start = 1'b0; voxel_count = AB'(5);
    check_eq("busy_after_start", busy, 1'b1);
    if (busy_start) begin
      repeat (3) @(negedge clock);
      start = 1'b1; voxel_count = AB'(9);
      @(negedge clock); start = 1'b0;
    end
    seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clock);
      if (frame_done) seen = 1;
    end
    check_eq("frame_done_seen", seen, 1'b1);
    if (done_start) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("idle_after_done", {busy, vmem_rd, do_shade}, 3'b000);
    check_eq("vmem_rd_count", rd_cnt - b_rd, cnt);
    check_eq("rasterize_count", rast_cnt - b_rast, cnt);
    check_eq("shade_count", shade_cnt - b_shade, 1);
    check_eq("frame_done_count", fdone_cnt - b_fd, 1);
    check_eq("voxels_left", vq.size(), 0);
    check_eq("pixels_left", pq.size(), 0);
  endtask

  initial begin
    int b_rast, b_sum;
    bit hit;
    #2;
    check_eq("reset_ctrl", {busy, frame_done, vmem_rd, do_rasterize, do_shade, out_valid}, 6'b0);
    check_eq("reset_voxel", {voxel_id, voxel_z, voxel_y, voxel_x, vmem_addr}, 42'b0);
    check_eq("reset_pixbus", {row, col, out_row, out_col, out_pixel}, 40'b0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("no_pulse_before_start", rd_cnt + rast_cnt + shade_cnt + fdone_cnt, 0);

    // One voxel, done 3 cycles after each pulse.
    mem[0] = '{id: 8'hA1, z: 8'h33, y: 8'h22, x: 8'h11};
    run_frame(1, 3, 0, 0, 0, 0);

    // Three voxels; a start while busy and a start in the DONE cycle are both ignored.
    mem[0] = '{id: 8'd5, z: 8'd1, y: 8'd2, x: 8'd3};
    mem[1] = '{id: 8'd6, z: 8'd4, y: 8'd5, x: 8'd6};
    mem[2] = '{id: 8'd7, z: 8'd7, y: 8'd8, x: 8'd9};
    run_frame(3, 3, 0, 0, 1, 1);

    // Empty frame straight to shading; accepted immediately in the IDLE after the previous DONE.
    run_frame(0, 4, 0, 0, 0, 0);

    // Shader 5 stays low 17 cycles beyond the rest.
    mem[0] = '{id: 8'h21, z: 8'h20, y: 8'h1F, x: 8'h1E};
    mem[1] = '{id: 8'h31, z: 8'h30, y: 8'h2F, x: 8'h2E};
    run_frame(2, 3, 17, 0, 0, 0);

    // Done levels never drop: the blanking cycle alone sets the pace.
    run_frame(2, 0, 0, 1, 0, 0);

    // Backpressure at pixel (1,2).
    bp_en = 1;
    run_frame(1, 2, 0, 0, 0, 0);
    check_eq("bp_exercised", bp_done, 1'b1);
    bp_en = 0;

    // Abort mid-frame during the second voxel's wait.
    mem[0] = '{id: 8'h41, z: 8'h42, y: 8'h43, x: 8'h44};
    mem[1] = '{id: 8'h51, z: 8'h52, y: 8'h53, x: 8'h54};
    mem[2] = '{id: 8'h61, z: 8'h62, y: 8'h63, x: 8'h64};
    b_rast = rast_cnt;
    prep_frame(3, 10, 0, 0);
    @(negedge clock); start = 1'b1; voxel_count = AB'(3);
    @(negedge clock); start = 1'b0;
    hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clock);
      if (rast_cnt - b_rast == 2) hit = 1;
    end
    check_eq("abort_reached_voxel2", rast_cnt - b_rast, 2);
    repeat (3) @(negedge clock);
    check_eq("abort_in_rwait", {busy, vmem_rd, do_rasterize, do_shade}, 4'b1000);
    reset = 1'b0;
    #1;
    check_eq("abort_ctrl", {busy, frame_done, vmem_rd, do_rasterize, do_shade, out_valid}, 6'b0);
    check_eq("abort_voxel", {voxel_id, voxel_z, voxel_y, voxel_x, vmem_addr}, 42'b0);
    vq.delete();
    pq.delete();
    rast_pending = 0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    b_sum = rd_cnt + rast_cnt + shade_cnt + fdone_cnt;
    repeat (6) @(negedge clock);
    check_eq("no_pulse_after_reset", rd_cnt + rast_cnt + shade_cnt + fdone_cnt - b_sum, 0);
    run_frame(2, 3, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
